gpio_wb_arbiter: RTL and testbench

Round-robin Wishbone arbiter and sequencer that shares the single slave port of `gpio_top` between `NUM_REQ` independent requesters, such as a CPU bridge, a test sequencer and an interrupt service engine. It accepts one register access per requester, runs exactly one classic Wishbone cycle at a time toward the GPIO core, and returns read data, completion and error status to the winning requester. It sits between the requester fabric and the `gpio_top` `wb_*` pins.

---
 rtl/gpio_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_gpio_wb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_wb_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone slave port between NUM_REQ requesters; grant 1 cycle after request, done 1 cycle after ack/err.
// Requesters stall on gnt_o/done_o; the slave stalls via wbm_ack_i. Optional bus timeout is enabled by defining GPIO_ARB_TIMEOUT_EN.
module gpio_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      req_we_i,
  input  logic [NUM_REQ*AW-1:0]   req_adr_i,
  input  logic [NUM_REQ*DW-1:0]   req_dat_i,
  input  logic [NUM_REQ*DW/8-1:0] req_sel_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      done_o,
  output logic [NUM_REQ-1:0]      err_o,
  output logic [DW-1:0]           rdata_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [AW-1:0]           wbm_adr_o,
  output logic [DW-1:0]           wbm_dat_o,
  output logic [DW/8-1:0]         wbm_sel_o,
  input  logic [DW-1:0]           wbm_dat_i,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rr_ptr, win, win_nxt;
  logic          any_req;
  logic          tmo_hit;
  logic          bus_end, bus_err;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    any_req = 1'b0;
    win_nxt = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req_i[idx]) begin
        any_req = 1'b1;
        win_nxt = PW'(idx);
      end
    end
  end

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_cnt <= '0;
    end else if (state == BUS) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Fires in the TMO_CYC-th BUS cycle so cyc drops after exactly TMO_CYC cycles.
  assign tmo_hit = (tmo_cnt == CW'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign bus_err = wbm_err_i | tmo_hit;
  assign bus_end = wbm_ack_i | bus_err;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUS;
      BUS:     if (bus_end) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      gnt_o     <= '0;
      done_o    <= '0;
      err_o     <= '0;
      rdata_o   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rr_ptr    <= '0;
      win       <= '0;
    end else begin
      done_o <= '0;
      err_o  <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_o     <= NUM_REQ'(1) << win_nxt;
            win       <= win_nxt;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= req_we_i[win_nxt];
            wbm_adr_o <= req_adr_i[int'(win_nxt)*AW +: AW];
            wbm_dat_o <= req_dat_i[int'(win_nxt)*DW +: DW];
            wbm_sel_o <= req_sel_i[int'(win_nxt)*SW +: SW];
          end
        end
        BUS: begin
          if (bus_end) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            done_o    <= gnt_o;
            err_o     <= bus_err ? gnt_o : '0;
            // A timeout carries no slave data, so only real responses update rdata.
            if (!wbm_we_o && (wbm_ack_i || wbm_err_i)) rdata_o <= wbm_dat_i;
          end
        end
        RESP: begin
          gnt_o  <= '0;
          rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// Randomized bench for gpio_wb_arbiter against a transaction-level round-robin model.
module tb_gpio_wb_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_i = '0, req_we_i = '0;
  logic [N*AW-1:0]   req_adr_i = '0;
  logic [N*DW-1:0]   req_dat_i = '0;
  logic [N*SW-1:0]   req_sel_i = '0;
  logic [N-1:0]      gnt_o, done_o, err_o;
  logic [DW-1:0]     rdata_o;
  logic              wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o;
  logic [SW-1:0]     wbm_sel_o;
  logic [DW-1:0]     wbm_dat_i = '0;
  logic              wbm_ack_i = 1'b0, wbm_err_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int ptr_m = 0;
  logic [DW-1:0] rdata_m = '0;

  gpio_wb_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .TMO_CYC(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_i(req_i), .req_we_i(req_we_i), .req_adr_i(req_adr_i),
    .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++)
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic scramble_fields();
    for (int k = 0; k < N; k++) begin
      req_we_i[k]           = 1'($urandom_range(0, 1));
      req_adr_i[k*AW +: AW] = AW'($urandom);
      req_dat_i[k*DW +: DW] = $urandom;
      req_sel_i[k*SW +: SW] = SW'($urandom);
    end
  endtask

  // One full access: grant, optional slave wait, response, then back to idle.
  task automatic txn(input logic [N-1:0] req, input int wt, input bit ack, input bit err,
                     output int w);
    logic [AW+DW+SW:0] fld_e;
    logic [DW-1:0]     sdat;
    logic              we_e;
    req_i = req;
    scramble_fields();
    w = pick(req, ptr_m);
    we_e  = req_we_i[w];
    fld_e = {we_e, req_adr_i[w*AW +: AW], req_dat_i[w*DW +: DW], req_sel_i[w*SW +: SW]};
    tick();
    chk("gnt", 64'(gnt_o), 64'(1 << w));
    chk("cyc_stb", 64'({wbm_cyc_o, wbm_stb_o}), 64'(2'b11));
    chk("fields", 64'({wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o}), 64'(fld_e));
    req_i = N'($urandom);
    scramble_fields();
    repeat (wt) tick();
    chk("fields_hold", 64'({wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o}), 64'({1'b1, fld_e}));
    sdat = $urandom;
    wbm_dat_i = sdat;
    wbm_ack_i = ack;
    wbm_err_i = err;
    tick();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    req_i = '0;
    if (!we_e) rdata_m = sdat;
    chk("done", 64'(done_o), 64'(1 << w));
    chk("err", 64'(err_o), err ? 64'(1 << w) : 64'(0));
    chk("rdata", 64'(rdata_o), 64'(rdata_m));
    chk("cyc_drop", 64'(wbm_cyc_o), 64'(0));
    tick();
    chk("idle", 64'({done_o, gnt_o}), 64'(0));
    ptr_m = (w + 1) % N;
  endtask

  initial begin
    int w;
    int n;
    // Reset state.
    repeat (3) tick();
    chk("rst_outs", 64'({gnt_o, done_o, err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o}), 64'(0));
    chk("rst_rdata", 64'(rdata_o), 64'(0));
    rst_n = 1'b1;
    tick();

    // Fairness under full load.
    for (int i = 0; i < 12; i++) begin
      txn(4'b1111, $urandom_range(0, 2), 1'b1, 1'b0, w);
      chk("rr_order", 64'(w), 64'(i % N));
    end

    // Single read with first-cycle ack.
    req_i = 4'b0001;
    scramble_fields();
    req_we_i[0] = 1'b0;
    req_adr_i[0 +: AW] = 8'h04;
    tick();
    chk("sr_gnt", 64'(gnt_o), 64'(4'b0001));
    chk("sr_adr", 64'({wbm_we_o, wbm_adr_o}), 64'({1'b0, 8'h04}));
    wbm_dat_i = 32'hA5A5_0001;
    wbm_ack_i = 1'b1;
    req_i = '0;
    tick();
    wbm_ack_i = 1'b0;
    chk("sr_done", 64'({done_o, err_o}), 64'({4'b0001, 4'b0000}));
    chk("sr_rdata", 64'(rdata_o), 64'(32'hA5A5_0001));
    rdata_m = 32'hA5A5_0001;
    tick();
    ptr_m = 1;

    // Pointer wrap: serve 2, then 0 and 1 contend.
    txn(4'b0100, 0, 1'b1, 1'b0, w);
    chk("wrap_2", 64'(w), 64'(2));
    txn(4'b0011, 1, 1'b1, 1'b0, w);
    chk("wrap_0", 64'(w), 64'(0));
    txn(4'b0011, 0, 1'b1, 1'b0, w);
    chk("wrap_1", 64'(w), 64'(1));

    // Error on a write, ack and err together.
    req_i = 4'b0100;
    scramble_fields();
    req_we_i[2] = 1'b1;
    tick();
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    wbm_dat_i = 32'hDEAD_BEEF;
    req_i = '0;
    tick();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    chk("we_done", 64'({done_o, err_o}), 64'({4'b0100, 4'b0100}));
    chk("we_rdata", 64'(rdata_o), 64'(rdata_m));
    tick();
    ptr_m = 3;

    // Stray responses while idle.
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    wbm_dat_i = 32'h1234_5678;
    tick();
    tick();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    chk("stray", 64'({done_o, err_o, gnt_o, wbm_cyc_o}), 64'(0));
    chk("stray_rdata", 64'(rdata_o), 64'(rdata_m));

    // Randomized accesses.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] r;
      int kind;
      r = N'($urandom_range(1, 15));
      kind = $urandom_range(0, 2);
      txn(r, $urandom_range(0, 3), kind != 1, kind != 0, w);
    end

`ifdef GPIO_ARB_TIMEOUT_EN
    // Silent slave: timeout after 16 BUS cycles.
    req_i = 4'b1111;
    scramble_fields();
    w = pick(4'b1111, ptr_m);
    tick();
    chk("tmo_gnt", 64'(gnt_o), 64'(1 << w));
    req_i = '0;
    n = 0;
    while (wbm_cyc_o && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'(16));
    chk("tmo_done", 64'({done_o, err_o}), 64'({4'(1 << w), 4'(1 << w)}));
    chk("tmo_rdata", 64'(rdata_o), 64'(rdata_m));
    tick();
    ptr_m = (w + 1) % N;
    txn(4'b1111, 0, 1'b1, 1'b0, n);
    chk("tmo_next", 64'(n), 64'((w + 1) % N));
`endif

    // Reset in the middle of a BUS wait.
    req_i = 4'b1000;
    scramble_fields();
    tick();
    chk("mid_gnt", 64'(gnt_o), 64'(4'b1000));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", 64'({wbm_cyc_o, wbm_stb_o, gnt_o, done_o}), 64'(0));
    req_i = '0;
    tick();
    chk("mid_rdata", 64'(rdata_o), 64'(0));
    rst_n = 1'b1;
    ptr_m = 0;
    rdata_m = '0;
    tick();
    chk("mid_nodone", 64'(done_o), 64'(0));
    txn(4'b0010, 0, 1'b1, 1'b0, w);
    chk("post_rst_gnt", 64'(w), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
